// File: rtl/apple_judge.sv
// Apple/wall judge for the snake game: detects eat and wall hits on each head step,
// relocates the apple from a free-running LFSR, keeps the score and flags apple pixels.
module apple_judge #(
    parameter int          GRID_W     = 40,
    parameter int          GRID_H     = 30,
    parameter int          CELL_SHIFT = 4,
    parameter int          APPLE_X0   = 30,
    parameter int          APPLE_Y0   = 15,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_TRIES  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       head_step,
    input  logic [5:0] head_x,
    input  logic [5:0] head_y,
    input  logic [3:0] cube_num,
    input  logic       restart,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic       add_cube,
    output logic       died,
    output logic [5:0] apple_x,
    output logic [5:0] apple_y,
    output logic [7:0] score,
    output logic       apple_pix,
    output logic       busy
);

    typedef enum logic [1:0] {PLAY, RELOC, DEAD} state_t;

    localparam int         TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [5:0] X_LAST   = 6'(GRID_W - 1);
    localparam logic [5:0] Y_LAST   = 6'(GRID_H - 1);
    localparam logic [5:0] X_IN_MAX = 6'(GRID_W - 2);
    localparam logic [5:0] Y_IN_MAX = 6'(GRID_H - 2);
    localparam logic [5:0] X_MID    = 6'(GRID_W / 2);
    localparam logic [5:0] X_MID1   = 6'(GRID_W / 2 + 1);
    localparam logic [5:0] Y_MID    = 6'(GRID_H / 2);
    localparam logic [5:0] X_RST    = 6'(APPLE_X0);
    localparam logic [5:0] Y_RST    = 6'(APPLE_Y0);
    localparam logic [9:0] PIX_W    = 10'(GRID_W << CELL_SHIFT);
    localparam logic [9:0] PIX_H    = 10'(GRID_H << CELL_SHIFT);

    state_t             state, state_nx;
    logic [15:0]        lfsr;
    logic [TRY_W-1:0]   tries;
    logic               pending;
    logic [5:0]         head_x_p0, head_y_p0;

    logic               ev, wall, eat, accept, give_up, pix_hit;
    logic [5:0]         ev_x, ev_y, cand_x, cand_y;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A fresh step overrides a step that was parked while relocating
    always_comb begin
        ev      = head_step | pending;
        ev_x    = head_step ? head_x : head_x_p0;
        ev_y    = head_step ? head_y : head_y_p0;
        wall    = (ev_x == 6'd0) || (ev_x >= X_LAST) || (ev_y == 6'd0) || (ev_y >= Y_LAST);
        eat     = (ev_x == apple_x) && (ev_y == apple_y);
        cand_x  = lfsr[5:0];
        cand_y  = lfsr[11:6];
        accept  = (cand_x >= 6'd1) && (cand_x <= X_IN_MAX) &&
                  (cand_y >= 6'd1) && (cand_y <= Y_IN_MAX) &&
                  !((cand_x == head_x_p0) && (cand_y == head_y_p0));
        give_up = (tries == TRY_W'(MAX_TRIES - 1));
        pix_hit = (pos_x < PIX_W) && (pos_y < PIX_H) &&
                  ((pos_x >> CELL_SHIFT) == 10'(apple_x)) &&
                  ((pos_y >> CELL_SHIFT) == 10'(apple_y));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= PLAY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (restart) begin
            state_nx = PLAY;
        end else begin
            case (state)
                PLAY:    if (ev && wall)           state_nx = DEAD;
                         else if (ev && eat)       state_nx = RELOC;
                RELOC:   if (accept || give_up)    state_nx = PLAY;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        busy = (state == RELOC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge clk) begin
        if (head_step && !restart && (state != DEAD)) begin
            head_x_p0 <= head_x;
            head_y_p0 <= head_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_cube <= 1'b0;
            died     <= 1'b0;
            apple_x  <= X_RST;
            apple_y  <= Y_RST;
            score    <= 8'd0;
            pending  <= 1'b0;
            tries    <= '0;
        end else begin
            add_cube <= 1'b0;
            if (restart) begin
                died    <= 1'b0;
                pending <= 1'b0;
                score   <= 8'd0;
                apple_x <= X_RST;
                apple_y <= Y_RST;
            end else begin
                case (state)
                    PLAY: begin
                        if (ev) begin
                            pending <= 1'b0;
                            if (wall) begin
                                died <= 1'b1;
                            end else if (eat) begin
                                add_cube <= (cube_num != 4'd15);
                                score    <= sat_inc(score);
                                tries    <= '0;
                            end
                        end
                    end
                    RELOC: begin
                        if (head_step) pending <= 1'b1;
                        if (accept) begin
                            apple_x <= cand_x;
                            apple_y <= cand_y;
                        end else if (give_up) begin
                            // Centre fallback, nudged right if the head sits on it
                            apple_x <= ((X_MID == head_x_p0) && (Y_MID == head_y_p0)) ? X_MID1 : X_MID;
                            apple_y <= Y_MID;
                        end else begin
                            tries <= tries + TRY_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pixel flag lags the scan coordinates by one clock
    always_ff @(posedge clk) begin
        if (!rst_n) apple_pix <= 1'b0;
        else        apple_pix <= pix_hit;
    end

endmodule

// File: tb/tb_apple_judge.sv
// Scoreboard bench for apple_judge: step/restart scenarios, LFSR-modelled relocation,
// score saturation, parked steps during relocation and the apple pixel flag.
module tb_apple_judge;

    logic       clk = 1'b0;
    logic       rst_n, head_step, restart;
    logic [5:0] head_x, head_y;
    logic [3:0] cube_num;
    logic [9:0] pos_x, pos_y;
    logic       add_cube, died, apple_pix, busy;
    logic [5:0] apple_x, apple_y;
    logic [7:0] score;

    always #10 clk = ~clk;

    apple_judge dut (
        .clk(clk), .rst_n(rst_n), .head_step(head_step), .head_x(head_x), .head_y(head_y),
        .cube_num(cube_num), .restart(restart), .pos_x(pos_x), .pos_y(pos_y),
        .add_cube(add_cube), .died(died), .apple_x(apple_x), .apple_y(apple_y),
        .score(score), .apple_pix(apple_pix), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       add;
        logic       dead;
        logic [7:0] sc;
    } exp_t;

    exp_t exp_q[$];
    logic pix_q[$];

    logic [5:0] cur_ax, cur_ay;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] m_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_next(m_lfsr);
    end

    function automatic void predict(input logic [15:0] l0, input logic [5:0] h0x, h0y, h1x, h1y,
                                    output int cyc, output logic [5:0] px, py);
        logic [15:0] cur;
        logic [5:0]  cx, cy, hx, hy;
        cur = l0;
        for (int t = 0; t < 64; t++) begin
            cx = cur[5:0];
            cy = cur[11:6];
            hx = (t == 0) ? h0x : h1x;
            hy = (t == 0) ? h0y : h1y;
            if (cx >= 6'd1 && cx <= 6'd38 && cy >= 6'd1 && cy <= 6'd28 && !(cx == hx && cy == hy)) begin
                cyc = t + 1; px = cx; py = cy;
                return;
            end
            cur = m_next(cur);
        end
        cyc = 64;
        px  = (h1x == 6'd20 && h1y == 6'd15) ? 6'd21 : 6'd20;
        py  = 6'd15;
    endfunction

    task automatic drive_step(input logic [5:0] x, y, input logic add_e, dead_e,
                              input logic [7:0] sc_e, input string name);
        exp_t e;
        @(negedge clk);
        head_step = 1'b1; head_x = x; head_y = y;
        exp_q.push_back('{add_e, dead_e, sc_e});
        @(negedge clk);
        head_step = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if (add_cube !== e.add) begin n_fail++; $display("FAIL %s add_cube: got %b want %b", name, add_cube, e.add); end
        n_tests++;
        if (died !== e.dead) begin n_fail++; $display("FAIL %s died: got %b want %b", name, died, e.dead); end
        n_tests++;
        if (score !== e.sc) begin n_fail++; $display("FAIL %s score: got %0d want %0d", name, score, e.sc); end
    endtask

    task automatic check_reloc(input int n0, input int exp_cyc, input logic [5:0] ex, ey, input string name);
        int n;
        n = n0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n != exp_cyc) begin n_fail++; $display("FAIL %s reloc cycles: got %0d want %0d", name, n, exp_cyc); end
        n_tests++;
        if (apple_x !== ex || apple_y !== ey) begin
            n_fail++; $display("FAIL %s apple: got (%0d,%0d) want (%0d,%0d)", name, apple_x, apple_y, ex, ey);
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; head_step = 1'b0; restart = 1'b0; head_x = 6'd0; head_y = 6'd0;
        cube_num = 4'd0; pos_x = 10'd0; pos_y = 10'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (add_cube !== 1'b0 || died !== 1'b0 || busy !== 1'b0 || apple_pix !== 1'b0) begin
            n_fail++; $display("FAIL reset flags: got add=%b died=%b busy=%b pix=%b want 0", add_cube, died, busy, apple_pix);
        end
        n_tests++;
        if (apple_x !== 6'd30 || apple_y !== 6'd15) begin
            n_fail++; $display("FAIL reset apple: got (%0d,%0d) want (30,15)", apple_x, apple_y);
        end
        n_tests++;
        if (score !== 8'd0) begin n_fail++; $display("FAIL reset score: got %0d want 0", score); end
        cur_ax = 6'd30; cur_ay = 6'd15;
    endtask

    task automatic test_no_eat();
        drive_step(6'd10, 6'd10, 1'b0, 1'b0, 8'd0, "no_eat");
        n_tests++;
        if (apple_x !== 6'd30 || apple_y !== 6'd15 || busy !== 1'b0) begin
            n_fail++; $display("FAIL no_eat apple/busy: got (%0d,%0d) busy=%b want (30,15) busy=0", apple_x, apple_y, busy);
        end
    endtask

    task automatic test_eat();
        int cyc;
        logic [5:0] px, py;
        drive_step(6'd30, 6'd15, 1'b1, 1'b0, 8'd1, "eat");
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL eat busy: got %b want 1", busy); end
        predict(m_lfsr, 6'd30, 6'd15, 6'd30, 6'd15, cyc, px, py);
        @(negedge clk);
        n_tests++;
        if (add_cube !== 1'b0) begin n_fail++; $display("FAIL eat pulse width: add_cube got %b want 0", add_cube); end
        check_reloc(1, cyc, px, py, "eat");
        n_tests++;
        if (apple_x < 6'd1 || apple_x > 6'd38 || apple_y < 6'd1 || apple_y > 6'd28 ||
            (apple_x == 6'd30 && apple_y == 6'd15)) begin
            n_fail++; $display("FAIL eat interior: got (%0d,%0d) want interior and not (30,15)", apple_x, apple_y);
        end
        cur_ax = px; cur_ay = py;
    endtask

    task automatic test_wall_dead();
        drive_step(6'd0, 6'd12, 1'b0, 1'b1, 8'd1, "wall");
        repeat (3) @(negedge clk);
        n_tests++;
        if (died !== 1'b1) begin n_fail++; $display("FAIL wall hold: died got %b want 1", died); end
        drive_step(cur_ax, cur_ay, 1'b0, 1'b1, 8'd1, "dead_step");
        n_tests++;
        if (busy !== 1'b0 || apple_x !== cur_ax || apple_y !== cur_ay) begin
            n_fail++; $display("FAIL dead frozen: got (%0d,%0d) busy=%b want (%0d,%0d) busy=0",
                               apple_x, apple_y, busy, cur_ax, cur_ay);
        end
        do_restart();
        n_tests++;
        if (died !== 1'b0 || score !== 8'd0 || apple_x !== 6'd30 || apple_y !== 6'd15 || busy !== 1'b0) begin
            n_fail++; $display("FAIL restart: got died=%b score=%0d apple=(%0d,%0d) busy=%b want 0,0,(30,15),0",
                               died, score, apple_x, apple_y, busy);
        end
        cur_ax = 6'd30; cur_ay = 6'd15;
    endtask

    task automatic test_restart_vs_step();
        @(negedge clk);
        restart = 1'b1; head_step = 1'b1; head_x = 6'd30; head_y = 6'd15;
        @(negedge clk);
        restart = 1'b0; head_step = 1'b0;
        @(negedge clk);
        n_tests++;
        if (add_cube !== 1'b0 || score !== 8'd0 || busy !== 1'b0 || died !== 1'b0) begin
            n_fail++; $display("FAIL restart_vs_step: got add=%b score=%0d busy=%b died=%b want 0,0,0,0",
                               add_cube, score, busy, died);
        end
    endtask

    task automatic test_score_sat();
        int cyc;
        logic [5:0] px, py;
        logic [7:0] exp_sc;
        exp_sc = 8'd0;
        cube_num = 4'd15;
        for (int i = 0; i < 258; i++) begin
            exp_sc = (exp_sc == 8'hFF) ? exp_sc : exp_sc + 8'd1;
            drive_step(cur_ax, cur_ay, 1'b0, 1'b0, exp_sc, "score_sat");
            predict(m_lfsr, cur_ax, cur_ay, cur_ax, cur_ay, cyc, px, py);
            check_reloc(0, cyc, px, py, "score_sat");
            cur_ax = px; cur_ay = py;
        end
        n_tests++;
        if (score !== 8'd255) begin n_fail++; $display("FAIL score_sat final: got %0d want 255", score); end
        cube_num = 4'd0;
        do_restart();
        cur_ax = 6'd30; cur_ay = 6'd15;
    endtask

    task automatic test_pending();
        int cyc;
        logic [5:0] px, py;
        drive_step(6'd30, 6'd15, 1'b1, 1'b0, 8'd1, "pending_eat");
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL pending busy: got %b want 1", busy); end
        predict(m_lfsr, 6'd30, 6'd15, 6'd39, 6'd5, cyc, px, py);
        head_step = 1'b1; head_x = 6'd39; head_y = 6'd5;
        @(negedge clk);
        head_step = 1'b0;
        check_reloc(1, cyc, px, py, "pending");
        @(negedge clk);
        n_tests++;
        if (died !== 1'b1 || add_cube !== 1'b0) begin
            n_fail++; $display("FAIL pending died: got died=%b add=%b want died=1 add=0", died, add_cube);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (died !== 1'b1 || score !== 8'd1 || apple_x !== px || apple_y !== py) begin
            n_fail++; $display("FAIL pending hold: got died=%b score=%0d apple=(%0d,%0d) want 1,1,(%0d,%0d)",
                               died, score, apple_x, apple_y, px, py);
        end
        do_restart();
    endtask

    task automatic test_apple_pix();
        int xs[$], ys[$];
        logic e;
        int pending_cmp;
        xs = '{480, 495, 487, 496, 479, 480, 480, 700, 495, 1000};
        ys = '{240, 255, 248, 240, 240, 256, 239, 240, 479, 245};
        for (int x = 470; x < 500; x += 3) begin xs.push_back(x); ys.push_back(247); end
        pending_cmp = 0;
        for (int i = 0; i <= xs.size(); i++) begin
            @(negedge clk);
            if (pending_cmp != 0) begin
                e = pix_q.pop_front();
                n_tests++;
                if (apple_pix !== e) begin
                    n_fail++; $display("FAIL apple_pix at (%0d,%0d): got %b want %b", xs[i-1], ys[i-1], apple_pix, e);
                end
            end
            if (i < xs.size()) begin
                pos_x = 10'(xs[i]);
                pos_y = 10'(ys[i]);
                pix_q.push_back(xs[i] < 640 && ys[i] < 480 && (xs[i] / 16) == 30 && (ys[i] / 16) == 15);
                pending_cmp = 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_eat();
        test_eat();
        test_wall_dead();
        test_restart_vs_step();
        test_score_sat();
        test_pending();
        test_apple_pix();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
